parity_split_ctrl: RTL and testbench
====================================

Name: parity_split_ctrl

Overview:
Sequencer that owns the address port of the 1-cycle-latency synchronous constant ROM. It walks DEPTH entries, classifies each word by bit 0, and stores odd and even words in two separate register banks in arrival order. A start/busy/done handshake runs each pass, and a combinational read port lets downstream logic fetch the sorted results once done fires.

Parameters:
DATA_W, 8, ROM word width
ADDR_W, 4, ROM address width
DEPTH, 8, number of ROM entries read per pass (addresses 0..DEPTH-1), 1 <= DEPTH <= 2**ADDR_W
BANK_DEPTH, 8, entries per bank (odd bank and even bank each)
CNT_W, $clog2(BANK_DEPTH+1), width of count outputs

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begins a pass when sampled in IDLE
busy  out  1  high from the edge after start is accepted until done is asserted
done  out  1  one-cycle pulse at pass completion
rom_addr  out  ADDR_W  address to ROM (ROM registers it; data valid next cycle)
rom_data  in  DATA_W  ROM output
odd_count  out  CNT_W  odd words stored this pass
even_count  out  CNT_W  even words stored this pass
overflow  out  1  sticky per pass; a word was dropped because its bank was full
rd_sel  in  1  0 = even bank, 1 = odd bank
rd_idx  in  $clog2(BANK_DEPTH)  bank entry index
rd_data  out  DATA_W  combinational bank[rd_sel][rd_idx]; 0 if rd_idx >= that bank's count

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: busy=0, done=0, rom_addr=0, odd_count=0, even_count=0, overflow=0, all bank entries 0, FSM=IDLE, capture pipeline flags 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: if start=1 at edge E0:
  - clear both counts and overflow (bank contents kept);
  - rom_addr<=0, busy<=1, go RUN.
- start is ignored in every state other than IDLE.
- RUN: at each edge, if rom_addr==DEPTH-1 go DRAIN (rom_addr held), else rom_addr<=rom_addr+1. Address k is presented during the cycle after edge E_k.
- Capture pipeline:
  - issue flag set for each cycle a new address is presented in RUN;
  - delayed one cycle to mark rom_data valid;
  - word for address k is captured at edge E_{k+2}.
- DRAIN: waits until the capture for address DEPTH-1 (edge E_{DEPTH+1}), then goes DONE.
- DONE: done=1 and busy=0 for exactly the cycle after edge E_{DEPTH+2}; next edge returns to IDLE. With DEPTH=8, done is high after E10.
- Classification:
  - rom_data[0]=1 writes odd bank[odd_count] and increments odd_count;
  - rom_data[0]=0 writes even bank[even_count] and increments even_count;
  - exactly one bank is written per captured word.
- Full bank: if the target count == BANK_DEPTH, the word is dropped, the count is unchanged, and overflow<=1 (stays set until the next start or reset).
- Counts never wrap.
- rd_data is pure combinational and valid in any state. Reading during a pass returns partially filled results. Out-of-range rd_idx returns 0.
- rom_addr never exceeds DEPTH-1; the ROM is never addressed outside 0..DEPTH-1 during a pass.
- Reset mid-pass aborts immediately:
  - all reset values apply, banks are cleared;
  - no done pulse;
  - in-flight ROM data is discarded (pipeline flags cleared).
- start on the same edge as rst: rst wins, FSM stays IDLE.

Test Plan:
- Bench ROM model with 1-cycle registered latency, contents 5,4,2,1,10,0,12,3; pulse start -> done high exactly one cycle after E10. odd_count=3, odd bank 5,1,3; even_count=5, even bank 4,2,10,0,12; overflow=0.
- Address trace in the same run -> rom_addr sequence 0..7 on consecutive cycles starting after E0, held at 7 through DRAIN, never 8 or above.
- BANK_DEPTH=4 with all-even ROM (0,2,4,...,14) -> even_count=4, bank 0,2,4,6; overflow=1; odd_count=0; done still pulses once.
- start held high continuously -> passes begin only from IDLE, one done per pass, no start accepted while busy=1. Second pass recounts from 0 with identical results.
- rst asserted at E5 of a pass -> next cycle busy=0, counts 0, rd_data=0 for all indices, no done. A fresh start then completes normally with correct counts.
- After a pass, rd_sel=1, rd_idx=3 with odd_count=3 -> rd_data=0; rd_sel=0, rd_idx=4 -> rd_data=12.

Source files
------------

// File: rtl/parity_split_ctrl.sv
// parity_split_ctrl: walks a 1-cycle-latency ROM and sorts each word
// by bit 0 into separate odd/even register banks, start/busy/done handshake.
module parity_split_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 8,
  parameter int BANK_DEPTH = 8,
  parameter int CNT_W      = $clog2(BANK_DEPTH + 1),
  localparam int IDX_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  odd_count,
  output logic [CNT_W-1:0]  even_count,
  output logic              overflow,
  input  logic              rd_sel,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(BANK_DEPTH);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q;
  logic                done_q;
  logic                issue_q;
  logic                valid_q;
  logic [CNT_W-1:0]    odd_cnt_q;
  logic [CNT_W-1:0]    even_cnt_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   odd_q  [BANK_DEPTH];
  logic [DATA_W-1:0]   even_q [BANK_DEPTH];

  logic                wr_odd_d;
  logic                wr_even_d;
  logic                drop_d;

  // classify the word arriving this cycle and decide which bank takes it
  always_comb begin
    wr_odd_d  = 1'b0;
    wr_even_d = 1'b0;
    drop_d    = 1'b0;
    if (valid_q) begin
      if (rom_data[0]) begin
        wr_odd_d = (odd_cnt_q != FULL);
      end else begin
        wr_even_d = (even_cnt_q != FULL);
      end
      drop_d = ~(wr_odd_d | wr_even_d);
    end
  end

  // pass sequencer: address walk, capture pipeline, counts and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      issue_q    <= 1'b0;
      valid_q    <= 1'b0;
      odd_cnt_q  <= '0;
      even_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= issue_q;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            odd_cnt_q  <= '0;
            even_cnt_q <= '0;
            ovf_q      <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            issue_q    <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (addr_q == LAST_A) begin
            issue_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (!valid_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (wr_odd_d) begin
        odd_cnt_q <= odd_cnt_q + CNT_W'(1);
      end
      if (wr_even_d) begin
        even_cnt_q <= even_cnt_q + CNT_W'(1);
      end
      if (drop_d) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // bank storage; words land at the current fill level of their bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        odd_q[i]  <= '0;
        even_q[i] <= '0;
      end
    end else begin
      if (wr_odd_d) begin
        odd_q[odd_cnt_q[IDX_W-1:0]] <= rom_data;
      end
      if (wr_even_d) begin
        even_q[even_cnt_q[IDX_W-1:0]] <= rom_data;
      end
    end
  end

  // read port: entries past the fill level read as zero
  always_comb begin
    rd_data = '0;
    if (rd_sel) begin
      if (CNT_W'(rd_idx) < odd_cnt_q) begin
        rd_data = odd_q[rd_idx];
      end
    end else begin
      if (CNT_W'(rd_idx) < even_cnt_q) begin
        rd_data = even_q[rd_idx];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = addr_q;
  assign odd_count  = odd_cnt_q;
  assign even_count = even_cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_parity_split_ctrl.sv
// tb_parity_split_ctrl: scoreboard bench for two sorter instances
// (bank depth 8 and 4) fed by registered ROM models.
module tb_parity_split_ctrl;

  localparam int DEPTH = 8;

  typedef struct packed {
    int               acc;
    int               dcyc;
    int               oc;
    int               ec;
    bit               ovf;
    logic [7:0][7:0]  ob;
    logic [7:0][7:0]  eb;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [3:0] addr0, addr1;
  logic [7:0] rdat0, rdat1;
  logic       busy0, busy1, done0, done1, ovf0, ovf1;
  logic [3:0] oc0, ec0;
  logic [2:0] oc1, ec1;
  logic       rsel0, rsel1;
  logic [2:0] ridx0;
  logic [1:0] ridx1;
  logic [7:0] rd0, rd1;

  logic       stim_rd, ssel, msel0;
  logic [2:0] sidx, midx0;

  logic [7:0] rom [2][8];
  item_t      q0[$];
  item_t      q1[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  assign rsel0 = stim_rd ? ssel : msel0;
  assign ridx0 = stim_rd ? sidx : midx0;

  parity_split_ctrl #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(DEPTH), .BANK_DEPTH(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0),
    .rom_addr(addr0), .rom_data(rdat0),
    .odd_count(oc0), .even_count(ec0), .overflow(ovf0),
    .rd_sel(rsel0), .rd_idx(ridx0), .rd_data(rd0)
  );

  parity_split_ctrl #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(DEPTH), .BANK_DEPTH(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1),
    .rom_addr(addr1), .rom_data(rdat1),
    .odd_count(oc1), .even_count(ec1), .overflow(ovf1),
    .rd_sel(rsel1), .rd_idx(ridx1), .rd_data(rd1)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered ROMs: data for the address sampled at an edge appears after it
  always @(posedge clk) begin
    rdat0 <= rom[0][addr0[2:0]];
    rdat1 <= rom[1][addr1[2:0]];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // reference: sort the ROM image by parity, cap each bank at bd
  function automatic item_t model(input int u);
    item_t      it;
    int         bd;
    logic [7:0] w;
    it = '0;
    bd = (u == 0) ? 8 : 4;
    for (int k = 0; k < DEPTH; k++) begin
      w = rom[u][k];
      if (w[0]) begin
        if (it.oc < bd) begin
          it.ob[it.oc] = w;
          it.oc++;
        end else begin
          it.ovf = 1'b1;
        end
      end else begin
        if (it.ec < bd) begin
          it.eb[it.ec] = w;
          it.ec++;
        end else begin
          it.ovf = 1'b1;
        end
      end
    end
    return it;
  endfunction

  task automatic issue(input int u, input bit push);
    item_t it;
    it = model(u);
    if (u == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    it.acc  = cyc;
    it.dcyc = cyc + DEPTH + 2;
    if (push) begin
      if (u == 0) q0.push_back(it);
      else        q1.push_back(it);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      fail("drain_timeout");
      q0.delete();
      q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // monitor: address trace, done timing, then counts and bank readout
  initial begin : monitor
    item_t it;
    msel0 = 1'b0;
    midx0 = '0;
    rsel1 = 1'b0;
    ridx1 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int u = 0; u < 2; u++) begin
          int   bd, sz, ad, got, exp;
          logic dn, bs;
          bd = (u == 0) ? 8 : 4;
          dn = (u == 0) ? done0 : done1;
          bs = (u == 0) ? busy0 : busy1;
          ad = (u == 0) ? int'(addr0) : int'(addr1);
          sz = (u == 0) ? q0.size() : q1.size();
          chk("addr_in_range", int'(ad < DEPTH), 1);
          if (sz != 0) it = (u == 0) ? q0[0] : q1[0];
          if (sz != 0 && cyc >= it.acc && cyc <= it.acc + DEPTH + 1) begin
            if (u == 0) begin
              exp = cyc - it.acc;
              if (exp > DEPTH - 1) exp = DEPTH - 1;
              chk("addr_trace", ad, exp);
            end
            chk("busy_in_pass", int'(bs), 1);
          end
          if (dn) begin
            if (sz == 0) begin
              fail("unexpected_done");
            end else begin
              if (u == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
              chk("done_cycle", cyc, it.dcyc);
              chk("busy_at_done", int'(bs), 0);
              chk("odd_count", (u == 0) ? int'(oc0) : int'(oc1), it.oc);
              chk("even_count", (u == 0) ? int'(ec0) : int'(ec1), it.ec);
              chk("overflow", (u == 0) ? int'(ovf0) : int'(ovf1),
                  int'(it.ovf));
              for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < bd; i++) begin
                  if (u == 0) begin
                    msel0 = s[0];
                    midx0 = 3'(i);
                  end else begin
                    rsel1 = s[0];
                    ridx1 = 2'(i);
                  end
                  #1;
                  got = (u == 0) ? int'(rd0) : int'(rd1);
                  exp = (s == 1) ? int'(it.ob[i]) : int'(it.eb[i]);
                  chk(s == 1 ? "odd_bank" : "even_bank", got, exp);
                end
              end
            end
          end else if (sz != 0 && cyc > it.dcyc) begin
            fail("missing_done");
            if (u == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    rst     = 1'b1;
    start0  = 1'b0;
    start1  = 1'b0;
    stim_rd = 1'b0;
    ssel    = 1'b0;
    sidx    = '0;
    for (int k = 0; k < 8; k++) begin
      rom[0][k] = '0;
      rom[1][k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_addr0", int'(addr0), 0);
    chk("rst_oc0", int'(oc0), 0);
    chk("rst_ec0", int'(ec0), 0);
    chk("rst_ovf0", int'(ovf0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_addr1", int'(addr1), 0);
    chk("rst_oc1", int'(oc1), 0);
    chk("rst_ec1", int'(ec1), 0);
    chk("rst_ovf1", int'(ovf1), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed images: mixed parity, and all-even into the shallow bank
    rom[0][0] = 8'd5;  rom[0][1] = 8'd4;
    rom[0][2] = 8'd2;  rom[0][3] = 8'd1;
    rom[0][4] = 8'd10; rom[0][5] = 8'd0;
    rom[0][6] = 8'd12; rom[0][7] = 8'd3;
    for (int k = 0; k < 8; k++) rom[1][k] = 8'(2 * k);
    issue(0, 1'b1);
    issue(1, 1'b1);
    drain();

    // start held high: passes restart only once back in IDLE
    begin
      item_t it;
      it = model(0);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      it.acc  = cyc;
      it.dcyc = cyc + DEPTH + 2;
      q0.push_back(it);
      it.acc  = cyc + DEPTH + 4;
      it.dcyc = it.acc + DEPTH + 2;
      q0.push_back(it);
    end
    n = 0;
    while (q0.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    if (q0.size() != 0) begin
      fail("held_start_timeout");
      q0.delete();
    end
    drain();

    // reset at the fifth edge of a pass aborts it
    issue(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_oc", int'(oc0), 0);
    chk("abort_ec", int'(ec0), 0);
    chk("abort_ovf", int'(ovf0), 0);
    chk("abort_addr", int'(addr0), 0);
    stim_rd = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        ssel = s[0];
        sidx = 3'(i);
        #1;
        chk("abort_rd", int'(rd0), 0);
      end
    end
    stim_rd = 1'b0;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(0, 1'b1);
    drain();

    // random images on both instances, overlapping passes
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        rom[0][k] = 8'($urandom_range(0, 255));
        rom[1][k] = 8'($urandom_range(0, 255));
      end
      issue(0, 1'b1);
      issue(1, 1'b1);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
